// File: rtl/inverse_key_schedule.sv
// Buffers the 13 forward Anubis-128 round keys and streams them out in reverse order
// as decryption round keys, applying theta to the inner keys on the way out.
module inverse_key_schedule (
  input  logic         clk,
  input  logic         reset,
  input  logic         clk_en,
  input  logic         clear,
  input  logic         wr_valid,
  input  logic [127:0] wr_key,
  input  logic         rd_req,
  output logic [127:0] rd_key,
  output logic         rd_valid,
  output logic [3:0]   rd_index,
  output logic         full,
  output logic         busy
);

  typedef enum logic [1:0] {FILL, READY, DRAIN} state_t;

  localparam logic [3:0] LAST_IDX = 4'd12;

  state_t       r_state, w_state_next;
  logic [3:0]   r_wr_ptr, w_wr_ptr_next;
  logic [3:0]   r_rd_ptr, w_rd_ptr_next;
  logic         w_serve;
  logic         w_mem_we;
  logic [127:0] r_mem [0:12];
  logic [127:0] r_rd_key;
  logic         r_rd_valid;
  logic [3:0]   r_rd_index;
  logic [3:0]   w_rd_addr;
  logic [127:0] w_mem_rd;
  logic [127:0] w_theta;
  logic         w_use_theta;
  logic [127:0] w_rd_key_next;

  // Multiply by x modulo x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1D : 8'h00);
  endfunction

  // Multiply by h[sel], h = (01,02,04,06).
  function automatic logic [7:0] mul_h(input logic [7:0] b, input logic [1:0] sel);
    logic [7:0] m2;
    logic [7:0] m4;
    m2 = xtime(b);
    m4 = xtime(m2);
    case (sel)
      2'd0:    return b;
      2'd1:    return m2;
      2'd2:    return m4;
      default: return m4 ^ m2;
    endcase
  endfunction

  // Key r is K(12-r); READY has rd_ptr=0 so the same address covers the first key.
  assign w_rd_addr   = LAST_IDX - r_rd_ptr;
  assign w_mem_rd    = r_mem[w_rd_addr];
  assign w_use_theta = (r_rd_ptr != 4'd0) && (r_rd_ptr != LAST_IDX);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
      for (genvar gj = 0; gj < 4; gj++) begin : g_col
        assign w_theta[127-8*(4*gi+gj) -: 8] =
            mul_h(w_mem_rd[127-8*(4*gi+0) -: 8], 2'(gj ^ 0)) ^
            mul_h(w_mem_rd[127-8*(4*gi+1) -: 8], 2'(gj ^ 1)) ^
            mul_h(w_mem_rd[127-8*(4*gi+2) -: 8], 2'(gj ^ 2)) ^
            mul_h(w_mem_rd[127-8*(4*gi+3) -: 8], 2'(gj ^ 3));
      end
    end
  endgenerate

  assign w_rd_key_next = w_use_theta ? w_theta : w_mem_rd;

  always_comb begin
    w_state_next  = r_state;
    w_wr_ptr_next = r_wr_ptr;
    w_rd_ptr_next = r_rd_ptr;
    w_serve       = 1'b0;
    w_mem_we      = 1'b0;
    if (clear) begin
      w_state_next  = FILL;
      w_wr_ptr_next = 4'd0;
      w_rd_ptr_next = 4'd0;
    end else begin
      case (r_state)
        FILL: if (wr_valid) begin
          w_mem_we      = 1'b1;
          w_wr_ptr_next = r_wr_ptr + 4'd1;
          if (r_wr_ptr == LAST_IDX) w_state_next = READY;
        end
        READY: if (rd_req) begin
          w_serve       = 1'b1;
          w_rd_ptr_next = 4'd1;
          w_state_next  = DRAIN;
        end
        DRAIN: if (rd_req) begin
          w_serve = 1'b1;
          if (r_rd_ptr == LAST_IDX) begin
            w_rd_ptr_next = 4'd0;
            w_state_next  = READY;
          end else begin
            w_rd_ptr_next = r_rd_ptr + 4'd1;
          end
        end
        default: w_state_next = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= FILL;
      r_wr_ptr   <= 4'd0;
      r_rd_ptr   <= 4'd0;
      r_rd_key   <= '0;
      r_rd_index <= 4'd0;
      r_rd_valid <= 1'b0;
    end else if (clk_en) begin
      r_state    <= w_state_next;
      r_wr_ptr   <= w_wr_ptr_next;
      r_rd_ptr   <= w_rd_ptr_next;
      r_rd_valid <= w_serve;
      if (w_serve) begin
        r_rd_key   <= w_rd_key_next;
        r_rd_index <= r_rd_ptr;
      end
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

  // Key storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (clk_en && w_mem_we) r_mem[r_wr_ptr] <= wr_key;
  end

  assign rd_key   = r_rd_key;
  assign rd_valid = r_rd_valid;
  assign rd_index = r_rd_index;
  assign full     = (r_state != FILL);
  assign busy     = (r_state == DRAIN);

endmodule

// File: tb/tb_inverse_key_schedule.sv
// Directed self-checking bench for inverse_key_schedule: fill, drain, ignore,
// clock gating, clear and asynchronous reset scenarios.
module tb_inverse_key_schedule;

  logic         clk = 1'b0;
  logic         reset;
  logic         clk_en;
  logic         clear;
  logic         wr_valid;
  logic [127:0] wr_key;
  logic         rd_req;
  logic [127:0] rd_key;
  logic         rd_valid;
  logic [3:0]   rd_index;
  logic         full;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] keys [0:12];

  inverse_key_schedule dut (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clk_en),
    .clear    (clear),
    .wr_valid (wr_valid),
    .wr_key   (wr_key),
    .rd_req   (rd_req),
    .rd_key   (rd_key),
    .rd_valid (rd_valid),
    .rd_index (rd_index),
    .full     (full),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Generic shift-and-add GF(2^8) multiply, poly 0x11D.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ aa;
      aa = aa[7] ? (8'(aa << 1) ^ 8'h1D) : 8'(aa << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] theta_model(input logic [127:0] a);
    logic [7:0]   h [4];
    logic [7:0]   acc;
    logic [127:0] b;
    h[0] = 8'h01; h[1] = 8'h02; h[2] = 8'h04; h[3] = 8'h06;
    b = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(a[127-8*(4*i+k) -: 8], h[k ^ j]);
        b[127-8*(4*i+j) -: 8] = acc;
      end
    return b;
  endfunction

  function automatic logic [127:0] exp_key(input int r);
    if (r == 0)  return keys[12];
    if (r == 12) return keys[0];
    return theta_model(keys[12-r]);
  endfunction

  task automatic build_keys(input int set);
    for (int i = 0; i < 13; i++) keys[i] = {$urandom, $urandom, $urandom, $urandom};
    if (set == 0) begin
      keys[0]  = {16{8'hAA}};
      keys[10] = {8'h80, 120'h0};
      keys[11] = {8'h01, 120'h0};
      keys[12] = {16{8'hCC}};
    end else if (set == 1) begin
      keys[0]  = {16{8'h55}};
      keys[11] = {8'h02, 120'h0};
      keys[12] = {16{8'h33}};
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; clk_en = 1'b1; clear = 1'b0; wr_valid = 1'b0; wr_key = '0; rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (rd_key !== 128'h0) begin n_bad++; $display("FAIL reset_rd_key got %h want 0", rd_key); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    n_cmp++; if (rd_index !== 4'd0) begin n_bad++; $display("FAIL reset_rd_index got %0d want 0", rd_index); end
    n_cmp++; if ({full, busy} !== 2'b00) begin n_bad++; $display("FAIL reset_full_busy got %b want 00", {full, busy}); end
    reset = 1'b0;
    $display("reset released");
  endtask

  // rd_req held high throughout; it must be ignored while filling.
  task automatic test_fill;
    for (int i = 0; i < 13; i++) begin
      wr_valid = 1'b1; wr_key = keys[i]; rd_req = 1'b1;
      @(posedge clk);
      #1;
      $display("wr K%0d = %h", i, keys[i]);
      n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL fill_rd_valid i=%0d got %b want 0", i, rd_valid); end
      n_cmp++; if (full !== (i == 12)) begin n_bad++; $display("FAIL fill_full i=%0d got %b want %b", i, full, (i == 12)); end
    end
    wr_valid = 1'b0; rd_req = 1'b0;
  endtask

  task automatic drain_pass(input int gate_after, input bit noise, input bit hand, input int stop_at);
    logic [127:0] want;
    for (int r = 0; r < 13; r++) begin
      rd_req = 1'b1; wr_valid = noise; wr_key = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      want = exp_key(r);
      $display("rd r=%0d valid=%b idx=%0d key=%h", r, rd_valid, rd_index, rd_key);
      n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL drain_valid r=%0d got %b want 1", r, rd_valid); end
      n_cmp++; if (rd_index !== 4'(r)) begin n_bad++; $display("FAIL drain_index got %0d want %0d", rd_index, r); end
      n_cmp++; if (rd_key !== want) begin n_bad++; $display("FAIL drain_key r=%0d got %h want %h", r, rd_key, want); end
      if (hand) begin
        if (r == 0)  want = {16{8'hCC}};
        if (r == 1)  want = {32'h01020406, 96'h0};
        if (r == 2)  want = {32'h801D3A27, 96'h0};
        if (r == 12) want = {16{8'hAA}};
        if (r == 0 || r == 1 || r == 2 || r == 12) begin
          n_cmp++; if (rd_key !== want) begin n_bad++; $display("FAIL hand_key r=%0d got %h want %h", r, rd_key, want); end
        end
      end
      if (r == gate_after) begin
        clk_en = 1'b0;
        repeat (5) begin
          @(posedge clk);
          #1;
          n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL gate_valid got %b want 0", rd_valid); end
          n_cmp++; if (rd_index !== 4'(r)) begin n_bad++; $display("FAIL gate_index got %0d want %0d", rd_index, r); end
          n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL gate_busy got %b want 1", busy); end
        end
        clk_en = 1'b1;
      end
      if (r == stop_at) return;
    end
    rd_req = 1'b0; wr_valid = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL ready_valid got %b want 0", rd_valid); end
    n_cmp++; if ({full, busy} !== 2'b10) begin n_bad++; $display("FAIL ready_full_busy got %b want 10", {full, busy}); end
  endtask

  task automatic test_drain;
    drain_pass(-1, 1'b0, 1'b1, -1);
  endtask

  task automatic test_back_to_back;
    drain_pass(-1, 1'b0, 1'b1, -1);
  endtask

  task automatic test_ignore_wr;
    wr_valid = 1'b1; wr_key = {4{32'hDEADBEEF}}; rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL ignore_ready_valid got %b want 0", rd_valid); end
    drain_pass(-1, 1'b1, 1'b1, -1);
  endtask

  task automatic test_gating;
    drain_pass(6, 1'b0, 1'b0, -1);
  endtask

  task automatic test_clear;
    logic [127:0] held;
    drain_pass(-1, 1'b0, 1'b0, 5);
    held = exp_key(5);
    clear = 1'b1; rd_req = 1'b1; wr_valid = 1'b1; wr_key = '1;
    @(posedge clk);
    #1;
    clear = 1'b0; rd_req = 1'b0; wr_valid = 1'b0;
    $display("clear at idx=5");
    n_cmp++; if ({full, busy} !== 2'b00) begin n_bad++; $display("FAIL clear_full_busy got %b want 00", {full, busy}); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL clear_valid got %b want 0", rd_valid); end
    n_cmp++; if (rd_key !== held) begin n_bad++; $display("FAIL clear_key_hold got %h want %h", rd_key, held); end
    build_keys(1);
    test_fill;
    drain_pass(-1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_reset_async;
    drain_pass(-1, 1'b0, 1'b0, 7);
    rd_req = 1'b0;
    #3 reset = 1'b1;
    #1;
    $display("async reset mid-drain");
    n_cmp++; if (rd_key !== 128'h0) begin n_bad++; $display("FAIL areset_key got %h want 0", rd_key); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL areset_valid got %b want 0", rd_valid); end
    n_cmp++; if ({full, busy} !== 2'b00) begin n_bad++; $display("FAIL areset_full_busy got %b want 00", {full, busy}); end
    @(posedge clk);
    #1 reset = 1'b0;
    build_keys(2);
    test_fill;
    drain_pass(-1, 1'b0, 1'b0, -1);
  endtask

  initial begin
    test_reset;
    build_keys(0);
    test_fill;
    test_drain;
    test_back_to_back;
    test_ignore_wr;
    test_gating;
    test_clear;
    test_reset_async;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inverse_key_schedule.md
INVERSE_KEY_SCHEDULE -- requirements
Module: inverse_key_schedule

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port: clk_en  input  1  qualifies every state, pointer and output update.
REQ-004 SHALL have port: clear  input  1  synchronous abort to FILL; priority over wr_valid and rd_req.
REQ-005 SHALL have port: wr_valid  input  1  wr_key holds forward round key K_wr_ptr.
REQ-006 SHALL have port: wr_key  input  128  forward round key; byte a[i][j] at bits [127-8(4i+j) -: 8].
REQ-007 SHALL have port: rd_req  input  1  request next decryption round key.
REQ-008 SHALL have port: rd_key  output  128  registered decryption round key K'_r.
REQ-009 SHALL have port: rd_valid  output  1  one-cycle pulse; rd_key and rd_index valid.
REQ-010 SHALL have port: rd_index  output  4  index r (0..12) of the key on rd_key.
REQ-011 SHALL have port: full  output  1  all 13 forward keys stored.
REQ-012 SHALL have port: busy  output  1  high in DRAIN.

Function
REQ-013 SHALL store 13 forward round keys K0..K12 (Anubis-128, R=12) in an internal 13x128 buffer.
REQ-014 SHALL implement states FILL, READY and DRAIN, with a 4-bit wr_ptr and a 4-bit rd_ptr.
REQ-015 FILL: SHALL, on clk_en&wr_valid, write wr_key to mem[wr_ptr] and increment wr_ptr; after the write at wr_ptr=12, SHALL enter READY with full=1; rd_req SHALL be ignored.
REQ-016 READY: on clk_en&rd_req, SHALL load rd_key=mem[12], rd_index=0, rd_valid=1, rd_ptr=1, and enter DRAIN; wr_valid SHALL be ignored.
REQ-017 DRAIN: on clk_en&rd_req with rd_ptr=r, SHALL load rd_key=theta(mem[12-r]) for 1<=r<=11, and rd_key=mem[0] for r=12; SHALL set rd_index=r and rd_valid=1.
REQ-018 DRAIN: after serving r=12, SHALL return to READY with rd_ptr=0 and contents retained, so keys are re-readable for every block; wr_valid SHALL be ignored.
REQ-019 Read latency SHALL be 1 cycle: rd_key/rd_valid appear on the edge that samples rd_req.
REQ-020 rd_valid SHALL be 0 on every edge where no key is served, including clk_en=0 edges; rd_key and rd_index SHALL hold their last values.
REQ-021 clk_en=0 SHALL freeze state, pointers, memory, full and busy.
REQ-022 theta SHALL compute b=a·H with H=had(01,02,04,06) over GF(2^8) mod x^8+x^4+x^3+x^2+1 (0x11D): b[i][j]=XOR_k a[i][k]·H[k][j], where H[k][j]=h[k XOR j] and h=(01,02,04,06); theta SHALL be combinational inside the read path.
REQ-023 clear&clk_en SHALL set state=FILL, wr_ptr=0, rd_ptr=0, full=0, busy=0 and rd_valid=0; memory and rd_key SHALL be unchanged.

Reset
REQ-024 reset=1 SHALL asynchronously force state=FILL, wr_ptr=0, rd_ptr=0, rd_key=0, rd_index=0, rd_valid=0, full=0 and busy=0, including mid-FILL and mid-DRAIN; memory contents need not be cleared.
REQ-025 After reset release, the first valid write SHALL land in mem[0].

Verification
REQ-026 Fill: write K0=all 0xAA, K10=0x80 in byte0 with all other bytes 0, K11=0x01 in byte0 with all other bytes 0, K12=all 0xCC, and the others arbitrary -> full rises on the edge after the 13th write.
REQ-027 Drain: 13 back-to-back rd_req -> rd_index 0..12, with rd_key(0)=all 0xCC, rd_key(1)=0x01020406 followed by 96 zero bits, rd_key(2)=0x801D3A27 followed by 96 zero bits, rd_key(12)=all 0xAA; then READY, and a second pass is identical.
REQ-028 Ignore: rd_req held high during FILL -> rd_valid stays 0. wr_valid during READY/DRAIN -> readback unchanged.
REQ-029 Gating: clk_en=0 for 5 cycles mid-DRAIN with rd_req=1 -> no rd_valid and rd_index frozen; the sequence resumes at the next index.
REQ-030 Clear: clear at rd_index=5 -> full=0 and state FILL; refill with new keys -> readback reflects the new keys.
REQ-031 Reset: reset asserted asynchronously mid-DRAIN -> rd_key=0, rd_valid=0 and full=0 before the next clock edge.
